// File: rtl/gpu_cmd_sequencer_if.sv
// gpu_cmd_sequencer_if: command push port, gpu control fields/strobes and status of the sequencer
interface gpu_cmd_sequencer_if #(
  parameter int FB_WIDTH = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH = 8
);
  localparam int WW = $clog2(FB_WIDTH) + 2;
  localparam int HW = $clog2(FB_HEIGHT) + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_type;
  logic [31:0] cmd_address;
  logic [15:0] cmd_address_x;
  logic [15:0] cmd_address_y;
  logic [15:0] cmd_image_width;
  logic [WW-1:0] cmd_width;
  logic [HW-1:0] cmd_height;
  logic [WW-1:0] cmd_x;
  logic [HW-1:0] cmd_y;
  logic [15:0] cmd_clear_color;
  logic [31:0] ctrl_address;
  logic [15:0] ctrl_address_x;
  logic [15:0] ctrl_address_y;
  logic [15:0] ctrl_image_width;
  logic [WW-1:0] ctrl_width;
  logic [HW-1:0] ctrl_height;
  logic [WW-1:0] ctrl_x;
  logic [HW-1:0] ctrl_y;
  logic [15:0] ctrl_clear_color;
  logic ctrl_draw;
  logic ctrl_clear;
  logic gpu_busy;
  logic vblank;
  logic fb_swap;
  logic [CW-1:0] queue_count;
  logic idle;
  modport master (
    output cmd_valid, cmd_type, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
           cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color, gpu_busy, vblank,
    input  cmd_ready, ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
           ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color, ctrl_draw, ctrl_clear,
           fb_swap, queue_count, idle
  );
  modport slave (
    input  cmd_valid, cmd_type, cmd_address, cmd_address_x, cmd_address_y, cmd_image_width,
           cmd_width, cmd_height, cmd_x, cmd_y, cmd_clear_color, gpu_busy, vblank,
    output cmd_ready, ctrl_address, ctrl_address_x, ctrl_address_y, ctrl_image_width,
           ctrl_width, ctrl_height, ctrl_x, ctrl_y, ctrl_clear_color, ctrl_draw, ctrl_clear,
           fb_swap, queue_count, idle
  );
endinterface

// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: command FIFO popped in order into held gpu ctrl fields, edge strobes and vsync swaps
module gpu_cmd_sequencer #(
  parameter int FB_WIDTH = 400,
  parameter int FB_HEIGHT = 240,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  gpu_cmd_sequencer_if.slave bus
);
  localparam int WW = $clog2(FB_WIDTH) + 2;
  localparam int HW = $clog2(FB_HEIGHT) + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, VSYNC} state_t;
  typedef struct packed {
    logic [1:0] kind;
    logic [31:0] address;
    logic [15:0] address_x;
    logic [15:0] address_y;
    logic [15:0] image_width;
    logic [WW-1:0] width;
    logic [HW-1:0] height;
    logic [WW-1:0] x;
    logic [HW-1:0] y;
    logic [15:0] clear_color;
  } cmd_t;
  cmd_t mem [DEPTH];
  cmd_t head;
  state_t state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop, is_draw, vblank_q;
  assign head = mem[rd_ptr];
  assign bus.cmd_ready = count != CW'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign bus.queue_count = count;
  assign bus.idle = count == '0 && state == IDLE && !bus.gpu_busy;
  always_ff @(posedge clk)
    if (push)
      mem[wr_ptr] <= '{kind: bus.cmd_type, address: bus.cmd_address, address_x: bus.cmd_address_x,
                       address_y: bus.cmd_address_y, image_width: bus.cmd_image_width,
                       width: bus.cmd_width, height: bus.cmd_height, x: bus.cmd_x, y: bus.cmd_y,
                       clear_color: bus.cmd_clear_color};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      is_draw <= 1'b0;
      vblank_q <= 1'b0;
      bus.ctrl_address <= '0;
      bus.ctrl_address_x <= '0;
      bus.ctrl_address_y <= '0;
      bus.ctrl_image_width <= '0;
      bus.ctrl_width <= '0;
      bus.ctrl_height <= '0;
      bus.ctrl_x <= '0;
      bus.ctrl_y <= '0;
      bus.ctrl_clear_color <= '0;
      bus.ctrl_draw <= 1'b0;
      bus.ctrl_clear <= 1'b0;
      bus.fb_swap <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      vblank_q <= bus.vblank;
      bus.fb_swap <= 1'b0;
      case (state)
        IDLE:
          if (pop) begin
            is_draw <= head.kind == 2'd0;
            if (head.kind == 2'd0) begin
              bus.ctrl_address <= head.address;
              bus.ctrl_address_x <= head.address_x;
              bus.ctrl_address_y <= head.address_y;
              bus.ctrl_image_width <= head.image_width;
              bus.ctrl_width <= head.width;
              bus.ctrl_height <= head.height;
              bus.ctrl_x <= head.x;
              bus.ctrl_y <= head.y;
            end
            if (head.kind == 2'd1) bus.ctrl_clear_color <= head.clear_color;
            state <= head.kind == 2'd2 ? VSYNC : head.kind == 2'd3 ? IDLE : ISSUE;
          end
        ISSUE: begin
          bus.ctrl_draw <= is_draw;
          bus.ctrl_clear <= !is_draw;
          state <= ACK;
        end
        ACK:
          if (bus.gpu_busy) begin
            bus.ctrl_draw <= 1'b0;
            bus.ctrl_clear <= 1'b0;
            state <= RUN;
          end
        RUN:
          if (!bus.gpu_busy) state <= IDLE;
        VSYNC:
          if (bus.vblank && !vblank_q) begin
            bus.fb_swap <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// tb_gpu_cmd_sequencer: table-driven and directed checks of the gpu command sequencer against a gpu model
module tb_gpu_cmd_sequencer;
  localparam int FB_WIDTH = 400;
  localparam int FB_HEIGHT = 240;
  localparam int DEPTH = 8;
  localparam int WW = $clog2(FB_WIDTH) + 2;
  localparam int HW = $clog2(FB_HEIGHT) + 2;
  localparam int FW = 96 + 2 * WW + 2 * HW;
  typedef struct {
    logic [1:0] kind;
    logic [31:0] addr;
    int w, h, x, y;
    logic [15:0] color;
    int exp_draws, exp_clears;
    logic [31:0] exp_addr;
    int exp_w, exp_x;
    logic [15:0] exp_color;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0;
  int busy_len = 128, busy_cnt = 0;
  logic hold_busy = 1'b0, strobe_q = 1'b0;
  int n_draw = 0, n_clear = 0, n_swap = 0, n_overlap = 0, n_unstable = 0;
  int strobe_len = 0, strobe_max = 0;
  logic prev_strobe = 1'b0, in_op = 1'b0;
  logic [15:0] clr_log[$];
  logic ev_log[$];
  logic [FW-1:0] snap = '0;
  always #5 clk = ~clk;
  gpu_cmd_sequencer_if #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .DEPTH(DEPTH)) bus ();
  gpu_cmd_sequencer #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  wire strobe = bus.ctrl_draw | bus.ctrl_clear;
  wire [FW-1:0] fields = {bus.ctrl_address, bus.ctrl_address_x, bus.ctrl_address_y, bus.ctrl_image_width,
                          bus.ctrl_width, bus.ctrl_height, bus.ctrl_x, bus.ctrl_y, bus.ctrl_clear_color};
  assign bus.gpu_busy = (strobe && !strobe_q) || busy_cnt != 0 || hold_busy;
  always @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      busy_cnt <= 0;
    end else begin
      strobe_q <= strobe;
      if (strobe && !strobe_q) busy_cnt <= busy_len - 1;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end
  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      in_op = 1'b0;
      strobe_len = 0;
    end else begin
      if ((bus.ctrl_draw && bus.ctrl_clear) || (bus.fb_swap && strobe)) n_overlap++;
      if (bus.fb_swap) n_swap++;
      if (strobe && !prev_strobe) begin
        snap = fields;
        in_op = 1'b1;
        ev_log.push_back(bus.ctrl_clear);
        if (bus.ctrl_draw) n_draw++;
        else begin
          n_clear++;
          clr_log.push_back(bus.ctrl_clear_color);
        end
      end else if (in_op) begin
        if (fields != snap) n_unstable++;
        if (!bus.gpu_busy) in_op = 1'b0;
      end
      strobe_len = strobe ? strobe_len + 1 : 0;
      if (strobe_len > strobe_max) strobe_max = strobe_len;
    end
    prev_strobe = strobe;
  end
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(logic [1:0] kind, logic [31:0] addr, int w, int h, int x, int y, logic [15:0] color);
    bus.cmd_type = kind;
    bus.cmd_address = addr;
    bus.cmd_address_x = 16'(x + 1);
    bus.cmd_address_y = 16'(y + 2);
    bus.cmd_image_width = 16'd320;
    bus.cmd_width = WW'(w);
    bus.cmd_height = HW'(h);
    bus.cmd_x = WW'(x);
    bus.cmd_y = HW'(y);
    bus.cmd_clear_color = color;
  endtask
  task automatic push(logic [1:0] kind, logic [31:0] addr, int w, int h, int x, int y, logic [15:0] color);
    int n = 0;
    load(kind, addr, w, h, x, y, color);
    while (!bus.cmd_ready && n < 2000) begin
      step(1);
      n++;
    end
    if (!bus.cmd_ready) check("push_ready_timeout", 64'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(string name, int bound);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.idle && n < bound);
    check(name, 64'(bus.idle), 1);
  endtask
  initial begin
    vec_t vt[6];
    int n, d0, c0, s0, pat;
    vt[0] = '{2'd0, 32'h0000_2000, 400, 240, 0, 0, 16'h7777, 1, 0, 32'h0000_2000, 400, 0, 16'h0000};
    vt[1] = '{2'd1, 32'h0000_DEAD, 5, 5, 5, 5, 16'h1234, 0, 1, 32'h0000_2000, 400, 0, 16'h1234};
    vt[2] = '{2'd3, 32'h0000_BEEF, 7, 7, 7, 7, 16'hFFFF, 0, 0, 32'h0000_2000, 400, 0, 16'h1234};
    vt[3] = '{2'd0, 32'h0000_3000, 1, 1, 399, 239, 16'h5555, 1, 0, 32'h0000_3000, 1, 399, 16'h1234};
    vt[4] = '{2'd1, 32'h0000_0000, 0, 0, 0, 0, 16'hF801, 0, 1, 32'h0000_3000, 1, 399, 16'hF801};
    vt[5] = '{2'd0, 32'hFFFF_FFFC, 255, 17, 144, 33, 16'h0000, 1, 0, 32'hFFFF_FFFC, 255, 144, 16'hF801};
    bus.vblank = 1'b0;
    load(2'd0, 32'h0000_1000, 16, 8, 10, 20, 16'h0000);
    bus.cmd_valid = 1'b1;
    step(3);
    check("rst_ready", 64'(bus.cmd_ready), 1);
    check("rst_count", 64'(bus.queue_count), 0);
    check("rst_draw", 64'(bus.ctrl_draw), 0);
    check("rst_clear", 64'(bus.ctrl_clear), 0);
    check("rst_swap", 64'(bus.fb_swap), 0);
    check("rst_addr", 64'(bus.ctrl_address), 0);
    check("rst_color", 64'(bus.ctrl_clear_color), 0);
    reset = 1'b0;
    step(1);
    bus.cmd_valid = 1'b0;
    check("first_push_count", 64'(bus.queue_count), 1);
    step(1);
    check("lat_addr", 64'(bus.ctrl_address), 32'h1000);
    check("lat_width", 64'(bus.ctrl_width), 16);
    check("lat_draw_low", 64'(bus.ctrl_draw), 0);
    step(1);
    check("lat_draw_high", 64'(bus.ctrl_draw), 1);
    check("lat_busy", 64'(bus.gpu_busy), 1);
    step(1);
    check("lat_draw_drop", 64'(bus.ctrl_draw), 0);
    n = 0;
    while (bus.gpu_busy && n < 300) begin
      step(1);
      n++;
    end
    check("busy_cycles", 64'(n), 127);
    check("idle_first", 64'(bus.idle), 0);
    check("hold_x", 64'(bus.ctrl_x), 10);
    check("hold_y", 64'(bus.ctrl_y), 20);
    check("hold_height", 64'(bus.ctrl_height), 8);
    step(1);
    check("idle_second", 64'(bus.idle), 1);
    busy_len = 3;
    for (int i = 0; i < 6; i++) begin
      d0 = n_draw;
      c0 = n_clear;
      push(vt[i].kind, vt[i].addr, vt[i].w, vt[i].h, vt[i].x, vt[i].y, vt[i].color);
      wait_idle($sformatf("vec%0d_idle", i), 200);
      check($sformatf("vec%0d_draws", i), 64'(n_draw - d0), 64'(vt[i].exp_draws));
      check($sformatf("vec%0d_clears", i), 64'(n_clear - c0), 64'(vt[i].exp_clears));
      check($sformatf("vec%0d_addr", i), 64'(bus.ctrl_address), 64'(vt[i].exp_addr));
      check($sformatf("vec%0d_width", i), 64'(bus.ctrl_width), 64'(vt[i].exp_w));
      check($sformatf("vec%0d_x", i), 64'(bus.ctrl_x), 64'(vt[i].exp_x));
      check($sformatf("vec%0d_color", i), 64'(bus.ctrl_clear_color), 64'(vt[i].exp_color));
    end
    busy_len = 5;
    clr_log.delete();
    ev_log.delete();
    push(2'd1, 32'h0, 0, 0, 0, 0, 16'hF801);
    push(2'd0, 32'h0000_4000, 32, 32, 50, 60, 16'h0);
    push(2'd1, 32'h0, 0, 0, 0, 0, 16'h0001);
    wait_idle("b2b_idle", 300);
    pat = 0;
    foreach (ev_log[i]) pat = pat * 2 + int'(ev_log[i]);
    check("b2b_events", 64'(ev_log.size()), 3);
    check("b2b_order", 64'(pat), 5);
    check("b2b_clr0", 64'(clr_log[0]), 16'hF801);
    check("b2b_clr1", 64'(clr_log[1]), 16'h0001);
    check("b2b_addr", 64'(bus.ctrl_address), 32'h4000);
    busy_len = 2;
    clr_log.delete();
    hold_busy = 1'b1;
    push(2'd0, 32'h0000_5000, 8, 8, 1, 1, 16'h0);
    step(4);
    check("stall_count", 64'(bus.queue_count), 0);
    check("stall_idle", 64'(bus.idle), 0);
    for (int i = 0; i < DEPTH; i++) push(2'd1, 32'h0, 0, 0, 0, 0, 16'(16'h0100 + i));
    check("fill_count", 64'(bus.queue_count), DEPTH);
    check("fill_ready", 64'(bus.cmd_ready), 0);
    load(2'd1, 32'h0, 0, 0, 0, 0, 16'hAAAA);
    bus.cmd_valid = 1'b1;
    step(3);
    check("full_ignore", 64'(bus.queue_count), DEPTH);
    hold_busy = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step(1);
      n++;
    end
    check("space_after_pop", 64'(bus.queue_count), DEPTH - 1);
    step(1);
    bus.cmd_valid = 1'b0;
    check("refill_count", 64'(bus.queue_count), DEPTH);
    wait_idle("fill_idle", 500);
    check("fill_log_size", 64'(clr_log.size()), DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) check($sformatf("fill_order%0d", i), 64'(clr_log[i]), 64'(16'h0100 + i));
    check("fill_last", 64'(clr_log[DEPTH]), 16'hAAAA);
    c0 = n_clear;
    hold_busy = 1'b1;
    push(2'd0, 32'h0000_6000, 4, 4, 2, 2, 16'h0);
    step(4);
    push(2'd1, 32'h0, 0, 0, 0, 0, 16'h0C0C);
    check("pp_before", 64'(bus.queue_count), 1);
    hold_busy = 1'b0;
    step(1);
    load(2'd1, 32'h0, 0, 0, 0, 0, 16'h0D0D);
    bus.cmd_valid = 1'b1;
    step(1);
    bus.cmd_valid = 1'b0;
    check("pp_count", 64'(bus.queue_count), 1);
    wait_idle("pp_idle", 200);
    check("pp_clears", 64'(n_clear - c0), 2);
    check("pp_last", 64'(bus.ctrl_clear_color), 16'h0D0D);
    busy_len = 3;
    s0 = n_swap;
    bus.vblank = 1'b1;
    push(2'd2, 32'h0, 0, 0, 0, 0, 16'h0);
    step(5);
    check("sync_high_noswap", 64'(n_swap - s0), 0);
    check("sync_waiting", 64'(bus.idle), 0);
    bus.vblank = 1'b0;
    step(3);
    check("sync_low_noswap", 64'(n_swap - s0), 0);
    bus.vblank = 1'b1;
    step(1);
    check("sync_swap_high", 64'(bus.fb_swap), 1);
    step(1);
    check("sync_swap_low", 64'(bus.fb_swap), 0);
    check("sync_swap_once", 64'(n_swap - s0), 1);
    check("sync_idle", 64'(bus.idle), 1);
    bus.vblank = 1'b0;
    hold_busy = 1'b1;
    push(2'd0, 32'h0000_7000, 4, 4, 3, 3, 16'h0);
    step(4);
    for (int i = 0; i < 3; i++) push(2'd1, 32'h0, 0, 0, 0, 0, 16'(16'h0E01 + i));
    check("mid_count", 64'(bus.queue_count), 3);
    reset = 1'b1;
    hold_busy = 1'b0;
    step(2);
    check("mid_rst_count", 64'(bus.queue_count), 0);
    check("mid_rst_draw", 64'(bus.ctrl_draw), 0);
    check("mid_rst_clear", 64'(bus.ctrl_clear), 0);
    check("mid_rst_addr", 64'(bus.ctrl_address), 0);
    check("mid_rst_ready", 64'(bus.cmd_ready), 1);
    check("mid_rst_idle", 64'(bus.idle), 1);
    reset = 1'b0;
    step(1);
    c0 = n_clear;
    clr_log.delete();
    push(2'd1, 32'h0, 0, 0, 0, 0, 16'h0F0F);
    wait_idle("post_rst_idle", 200);
    check("post_rst_clears", 64'(n_clear - c0), 1);
    check("post_rst_log", 64'(clr_log[0]), 16'h0F0F);
    check("post_rst_color", 64'(bus.ctrl_clear_color), 16'h0F0F);
    check("never_overlap", 64'(n_overlap), 0);
    check("fields_stable", 64'(n_unstable), 0);
    check("strobe_one_cycle", 64'(strobe_max), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
